// File: rtl/tlk2711_reg_if.sv
// ----------------------------------------------------------------------------
// tlk2711_reg_if
//   Register bus between the PS register bridge (already synchronised into
//   clk) and the TLK2711 register bank.
//
//   wen / waddr / wdata : single-cycle write strobe, byte address, data
//   ren / raddr         : single-cycle read strobe, byte address
//   rdata / rvalid      : read data, valid pulse two cycles after ren
//
//   master : the bridge side (drives the strobes)
//   slave  : the register bank side (returns read data)
// ----------------------------------------------------------------------------
interface tlk2711_reg_if;
    logic        wen;
    logic [15:0] waddr;
    logic [63:0] wdata;
    logic        ren;
    logic [15:0] raddr;
    logic [63:0] rdata;
    logic        rvalid;

    modport master (
        output wen, waddr, wdata, ren, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  wen, waddr, wdata, ren, raddr,
        output rdata, rvalid
    );
endinterface

// File: rtl/tlk2711_reg_bank.sv
// ----------------------------------------------------------------------------
// tlk2711_reg_bank
//   Multi-channel register bank for NUM_CH TLK2711 links. One 256-byte page
//   per link (addr[11:8] = channel) plus a global page at 0xF000.
//
//   Ports
//     clk, rst              : clock, synchronous active-high reset
//     bus                   : register bus (slave side)
//     o_tx_* / o_rx_*       : per-channel DMA configuration, decoded from
//                             the TX_ADDR/TX_LENGTH/TX_PACKET/RX_ADDR/RX_CTRL
//                             registers, NUM_CH lanes packed LSB-first
//     o_tx/rx_config_done   : one-cycle start pulses from TX_CFG / RX_CFG
//     i_*_interrupt         : one-cycle event strobes per channel
//     i_rx_* / i_*_loss     : event payloads, valid with their strobe
//     i_tx/rx_status        : live status, readable through the page
//     o_irq                 : registered level interrupt per channel
//     o_soft_rst            : programmable-length soft reset pulse
//
//   Reads have a fixed two-cycle latency. Every channel owns an event FIFO
//   fed by three capture registers (rx > tx > loss, one push per cycle) and
//   drained by reads of EVT_POP.
// ----------------------------------------------------------------------------
module tlk2711_reg_bank #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int EVT_DEPTH       = 8,
    parameter int SOFT_RST_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    tlk2711_reg_if.slave                 bus,

    output logic [NUM_CH*ADDR_WIDTH-1:0] o_tx_base_addr,
    output logic [NUM_CH*32-1:0]         o_tx_total_length,
    output logic [NUM_CH*16-1:0]         o_tx_packet_body,
    output logic [NUM_CH*16-1:0]         o_tx_packet_tail,
    output logic [NUM_CH*16-1:0]         o_tx_body_num,
    output logic [NUM_CH*3-1:0]          o_tx_mode,
    output logic [NUM_CH-1:0]            o_loopback_ena,
    output logic [NUM_CH-1:0]            o_tx_pre,
    output logic [NUM_CH*ADDR_WIDTH-1:0] o_rx_base_addr,
    output logic [NUM_CH-1:0]            o_rx_fifo_rd,
    output logic [NUM_CH-1:0]            o_tx_config_done,
    output logic [NUM_CH-1:0]            o_rx_config_done,

    input  logic [NUM_CH-1:0]            i_tx_interrupt,
    input  logic [NUM_CH-1:0]            i_rx_interrupt,
    input  logic [NUM_CH-1:0]            i_loss_interrupt,
    input  logic [NUM_CH*16-1:0]         i_rx_frame_length,
    input  logic [NUM_CH*16-1:0]         i_rx_frame_num,
    input  logic [NUM_CH*8-1:0]          i_rx_data_type,
    input  logic [NUM_CH-1:0]            i_rx_file_end_flag,
    input  logic [NUM_CH-1:0]            i_rx_checksum_flag,
    input  logic [NUM_CH*6-1:0]          i_rx_status,
    input  logic [NUM_CH*10-1:0]         i_tx_status,
    input  logic [NUM_CH-1:0]            i_sync_loss,
    input  logic [NUM_CH-1:0]            i_link_loss,

    output logic [NUM_CH-1:0]            o_irq,
    output logic                         o_soft_rst
);

    localparam int PW = $clog2(EVT_DEPTH);
    localparam int CW = $clog2(SOFT_RST_CYCLES + 1);

    localparam logic [PW:0]   PTR_ONE   = (PW+1)'(1);
    localparam logic [CW-1:0] SOFT_ONE  = CW'(1);
    localparam logic [CW-1:0] SOFT_LOAD = CW'(SOFT_RST_CYCLES);

    localparam logic [7:0] OFF_TX_CFG    = 8'h08;
    localparam logic [7:0] OFF_RX_CFG    = 8'h10;
    localparam logic [7:0] OFF_TX_ADDR   = 8'h20;
    localparam logic [7:0] OFF_TX_LENGTH = 8'h28;
    localparam logic [7:0] OFF_TX_PACKET = 8'h30;
    localparam logic [7:0] OFF_TX_STATUS = 8'h38;
    localparam logic [7:0] OFF_RX_ADDR   = 8'h40;
    localparam logic [7:0] OFF_RX_CTRL   = 8'h48;
    localparam logic [7:0] OFF_RX_STATUS = 8'h50;
    localparam logic [7:0] OFF_EVT_POP   = 8'h60;
    localparam logic [7:0] OFF_IRQ_MASK  = 8'h68;
    localparam logic [7:0] OFF_IRQ_STAT  = 8'h70;

    localparam logic [63:0] VERSION = 64'h0000_2711_0002_0000 | 64'(NUM_CH);
    // The tx event carries no payload, so its capture is a pending bit only.
    localparam logic [63:0] TX_EVT  = {4'd1, 44'h0, 16'h5AA5};

    // ---------------------------------------------------------------- state
    logic [63:0] tx_addr_q  [NUM_CH];
    logic [63:0] tx_len_q   [NUM_CH];
    logic [63:0] tx_pkt_q   [NUM_CH];
    logic [63:0] rx_addr_q  [NUM_CH];
    logic [63:0] rx_ctrl_q  [NUM_CH];
    logic [3:0]  irq_mask_q [NUM_CH];
    logic [3:0]  irq_stat_q [NUM_CH];
    logic [63:0] rx_cap_q   [NUM_CH];
    logic [63:0] loss_cap_q [NUM_CH];
    logic [PW:0] wr_ptr_q   [NUM_CH];
    logic [PW:0] rd_ptr_q   [NUM_CH];
    logic [63:0] evt_mem    [NUM_CH][EVT_DEPTH];

    logic [NUM_CH-1:0] rx_pend_q, tx_pend_q, loss_pend_q;
    logic [NUM_CH-1:0] tx_cfg_q, rx_cfg_q, irq_q;
    logic              s1_valid_q;
    logic [63:0]       s1_data_q;
    logic [CW-1:0]     soft_cnt_q;
    logic              soft_q;

    // --------------------------------------------------------------- decode
    logic       w_chan_page, r_chan_page, r_glob_page, soft_wr;
    logic [3:0] w_ch, r_ch;
    logic [7:0] w_off, r_off;

    assign w_chan_page = (bus.waddr[15:12] == 4'h0);
    assign w_ch        = bus.waddr[11:8];
    assign w_off       = bus.waddr[7:0];
    assign r_chan_page = (bus.raddr[15:12] == 4'h0);
    assign r_glob_page = (bus.raddr[15:12] == 4'hF);
    assign r_ch        = bus.raddr[11:8];
    assign r_off       = bus.raddr[7:0];
    assign soft_wr     = bus.wen && (bus.waddr == 16'hF000) && bus.wdata[0];

    // Channels at or above NUM_CH never match, so their writes fall away.
    logic [NUM_CH-1:0] wr_ch;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ch = '0;
        for (int c = 0; c < NUM_CH; c++)
            wr_ch[c] = bus.wen && w_chan_page && (w_ch == 4'(c));
    end

    // ----------------------------------------------------------- FIFO state
    logic [NUM_CH-1:0] evt_empty, evt_full;
    logic [63:0]       evt_head [NUM_CH];

    always_comb begin
        evt_empty = '0;
        evt_full  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            evt_empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            evt_full[c]  = (wr_ptr_q[c][PW] != rd_ptr_q[c][PW]) &&
                           (wr_ptr_q[c][PW-1:0] == rd_ptr_q[c][PW-1:0]);
            evt_head[c]  = evt_mem[c][rd_ptr_q[c][PW-1:0]];
        end
    end

    // ------------------------------------------------------------ read mux
    logic [63:0]       rd_data_c;
    logic [NUM_CH-1:0] pop_req;

    always_comb begin
        rd_data_c = '0;
        pop_req   = '0;
        if (bus.ren) begin
            if (r_glob_page) begin
                case (bus.raddr[11:0])
                    12'h008: rd_data_c = VERSION;
                    12'h010: rd_data_c = 64'(irq_q);
                    default: rd_data_c = '0;
                endcase
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_chan_page && (r_ch == 4'(c))) begin
                    case (r_off)
                        OFF_TX_ADDR:   rd_data_c = tx_addr_q[c];
                        OFF_TX_LENGTH: rd_data_c = tx_len_q[c];
                        OFF_TX_PACKET: rd_data_c = tx_pkt_q[c];
                        OFF_RX_ADDR:   rd_data_c = rx_addr_q[c];
                        OFF_RX_CTRL:   rd_data_c = rx_ctrl_q[c];
                        OFF_TX_STATUS: rd_data_c = {4'h9, 50'h0, i_tx_status[c*10 +: 10]};
                        OFF_RX_STATUS: rd_data_c = {4'hA, 54'h0, i_rx_status[c*6 +: 6]};
                        OFF_IRQ_MASK:  rd_data_c = {60'h0, irq_mask_q[c]};
                        OFF_IRQ_STAT:  rd_data_c = {60'h0, irq_stat_q[c]};
                        OFF_EVT_POP: begin
                            pop_req[c] = 1'b1;
                            rd_data_c  = evt_empty[c] ? 64'h0 : evt_head[c];
                        end
                        default:       rd_data_c = '0;
                    endcase
                end
            end
        end
    end

    // ----------------------------------------------- push arbitration / IRQ
    logic [NUM_CH-1:0] pop_ok, push_req, push_ok, sel_rx, sel_tx, sel_loss;
    logic [63:0]       push_data [NUM_CH];
    logic [3:0]        irq_set   [NUM_CH];
    logic [3:0]        irq_w1c   [NUM_CH];

    always_comb begin
        pop_ok   = '0;
        push_req = '0;
        push_ok  = '0;
        sel_rx   = '0;
        sel_tx   = '0;
        sel_loss = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop_ok[c]   = pop_req[c] && !evt_empty[c];
            sel_rx[c]   = rx_pend_q[c];
            sel_tx[c]   = tx_pend_q[c] && !rx_pend_q[c];
            sel_loss[c] = loss_pend_q[c] && !rx_pend_q[c] && !tx_pend_q[c];
            push_req[c] = rx_pend_q[c] || tx_pend_q[c] || loss_pend_q[c];
            // A pop in the same cycle frees the slot, so a full FIFO still
            // accepts the push.
            push_ok[c]  = push_req[c] && (!evt_full[c] || pop_ok[c]);
            push_data[c] = sel_rx[c] ? rx_cap_q[c] :
                           sel_tx[c] ? TX_EVT      : loss_cap_q[c];
            // rx has top priority and is always drained the cycle after its
            // capture, so only tx and loss can be overwritten while pending.
            irq_set[c] = {(i_tx_interrupt[c]   && tx_pend_q[c]   && !sel_tx[c])   ||
                          (i_loss_interrupt[c] && loss_pend_q[c] && !sel_loss[c]) ||
                          (push_req[c] && !push_ok[c]),
                          i_loss_interrupt[c], i_rx_interrupt[c], i_tx_interrupt[c]};
            irq_w1c[c] = (wr_ch[c] && (w_off == OFF_IRQ_STAT)) ? bus.wdata[3:0] : 4'h0;
        end
    end

    // ------------------------------------------------------ sequential core
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tx_addr_q[c]  <= '0;
                tx_len_q[c]   <= '0;
                tx_pkt_q[c]   <= '0;
                rx_addr_q[c]  <= '0;
                rx_ctrl_q[c]  <= '0;
                irq_mask_q[c] <= '0;
                irq_stat_q[c] <= '0;
                rx_cap_q[c]   <= '0;
                loss_cap_q[c] <= '0;
                wr_ptr_q[c]   <= '0;
                rd_ptr_q[c]   <= '0;
            end
            rx_pend_q   <= '0;
            tx_pend_q   <= '0;
            loss_pend_q <= '0;
            tx_cfg_q    <= '0;
            rx_cfg_q    <= '0;
            irq_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            soft_cnt_q  <= '0;
            soft_q      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ch[c]) begin
                    case (w_off)
                        OFF_TX_ADDR:   tx_addr_q[c]  <= bus.wdata;
                        OFF_TX_LENGTH: tx_len_q[c]   <= bus.wdata;
                        OFF_TX_PACKET: tx_pkt_q[c]   <= bus.wdata;
                        OFF_RX_ADDR:   rx_addr_q[c]  <= bus.wdata;
                        OFF_RX_CTRL:   rx_ctrl_q[c]  <= bus.wdata;
                        OFF_IRQ_MASK:  irq_mask_q[c] <= bus.wdata[3:0];
                        default: ;
                    endcase
                end
                tx_cfg_q[c] <= wr_ch[c] && (w_off == OFF_TX_CFG);
                rx_cfg_q[c] <= wr_ch[c] && (w_off == OFF_RX_CFG);

                if (i_rx_interrupt[c])
                    rx_cap_q[c] <= {4'd2, 18'h0, i_rx_data_type[c*8 +: 8],
                                    i_rx_file_end_flag[c], i_rx_checksum_flag[c],
                                    i_rx_frame_num[c*16 +: 16],
                                    i_rx_frame_length[c*16 +: 16]};
                if (i_loss_interrupt[c])
                    loss_cap_q[c] <= {4'd3, 52'h0, i_rx_status[c*6 +: 6],
                                      i_sync_loss[c], i_link_loss[c]};
                // A selected capture leaves this cycle whether pushed or dropped.
                rx_pend_q[c]   <= i_rx_interrupt[c]   || (rx_pend_q[c]   && !sel_rx[c]);
                tx_pend_q[c]   <= i_tx_interrupt[c]   || (tx_pend_q[c]   && !sel_tx[c]);
                loss_pend_q[c] <= i_loss_interrupt[c] || (loss_pend_q[c] && !sel_loss[c]);

                if (push_ok[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_ONE;
                if (pop_ok[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PTR_ONE;

                // Set after clear: a same-cycle event survives a W1C.
                irq_stat_q[c] <= (irq_stat_q[c] & ~irq_w1c[c]) | irq_set[c];
                irq_q[c]      <= |(irq_stat_q[c] & ~irq_mask_q[c]);
            end

            s1_valid_q <= bus.ren;
            s1_data_q  <= rd_data_c;
            bus.rvalid <= s1_valid_q;
            if (s1_valid_q) bus.rdata <= s1_data_q;

            if (soft_wr) begin
                soft_cnt_q <= SOFT_LOAD;
                soft_q     <= 1'b1;
            end else if (soft_cnt_q > SOFT_ONE) begin
                soft_cnt_q <= soft_cnt_q - SOFT_ONE;
            end else begin
                soft_cnt_q <= '0;
                soft_q     <= 1'b0;
            end
        end
    end

    // NOTE: the event storage has no reset; the pointers alone define which
    // entries are valid, and an empty pop returns zero rather than stale data.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push_ok[c]) evt_mem[c][wr_ptr_q[c][PW-1:0]] <= push_data[c];
    end

    // -------------------------------------------------------------- outputs
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign o_tx_base_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = tx_addr_q[g][ADDR_WIDTH-1:0];
        assign o_rx_base_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = rx_addr_q[g][ADDR_WIDTH-1:0];
        assign o_tx_total_length[g*32 +: 32] = tx_len_q[g][31:0];
        assign o_tx_packet_body[g*16 +: 16]  = tx_pkt_q[g][15:0];
        assign o_tx_body_num[g*16 +: 16]     = tx_pkt_q[g][31:16];
        assign o_tx_packet_tail[g*16 +: 16]  = tx_pkt_q[g][47:32];
        assign o_tx_mode[g*3 +: 3]           = tx_pkt_q[g][62:60];
        assign o_tx_pre[g]                   = tx_pkt_q[g][59];
        assign o_loopback_ena[g]             = tx_pkt_q[g][63];
        assign o_rx_fifo_rd[g]               = rx_ctrl_q[g][0];
    end

    assign o_tx_config_done = tx_cfg_q;
    assign o_rx_config_done = rx_cfg_q;
    assign o_irq            = irq_q;
    assign o_soft_rst       = soft_q;

endmodule

// File: doc/tlk2711_reg_bank.md
Name: tlk2711_reg_bank

Overview:
- Multi-channel successor to the single-link TLK2711 register manager, with one register page per link (NUM_CH links).
- Adds per-channel interrupt status/mask with write-1-to-clear (W1C), a per-channel interrupt event FIFO popped by reads, a read-valid strobe, and a programmable soft-reset pulse.
- Sits between the PS register bridge, which is already synchronised into clk, and the per-link TX/RX DMA and TLK2711 control logic.

Parameters:
- NUM_CH, 2, number of TLK2711 links (1..8).
- ADDR_WIDTH, 32, DDR address width per channel.
- EVT_DEPTH, 8, event FIFO depth per channel (power of 2, ≥2).
- SOFT_RST_CYCLES, 255, o_soft_rst pulse length in cycles.

Ports:
- clk  in  1  user clock.
- rst  in  1  synchronous active-high reset.
- i_reg_wen  in  1  register write strobe.
- i_reg_waddr  in  16  write byte address.
- i_reg_wdata  in  64  write data.
- i_reg_ren  in  1  register read strobe.
- i_reg_raddr  in  16  read byte address.
- o_reg_rdata  out  64  read data.
- o_reg_rvalid  out  1  read data valid, 1-cycle pulse.
- o_tx_base_addr  out  NUM_CH*ADDR_WIDTH  TX DDR base address, per channel.
- o_tx_total_length  out  NUM_CH*32  TX total length in bytes.
- o_tx_packet_body / o_tx_packet_tail / o_tx_body_num  out  NUM_CH*16 each  TX_PACKET fields [15:0] / [47:32] / [31:16].
- o_tx_mode  out  NUM_CH*3  TX_PACKET[62:60].
- o_loopback_ena  out  NUM_CH  TX_PACKET[63].
- o_tx_pre  out  NUM_CH  TX_PACKET[59].
- o_rx_base_addr  out  NUM_CH*ADDR_WIDTH  RX DDR base address.
- o_rx_fifo_rd  out  NUM_CH  RX_CTRL[0].
- o_tx_config_done / o_rx_config_done  out  NUM_CH  1-cycle start pulses.
- i_tx_interrupt / i_rx_interrupt / i_loss_interrupt  in  NUM_CH  1-cycle event strobes.
- i_rx_frame_length / i_rx_frame_num  in  NUM_CH*16  RX event payload, valid with i_rx_interrupt.
- i_rx_data_type  in  NUM_CH*8  RX event payload.
- i_rx_file_end_flag / i_rx_checksum_flag  in  NUM_CH  RX event payload.
- i_rx_status  in  NUM_CH*6  RX status.
- i_tx_status  in  NUM_CH*10  TX status.
- i_sync_loss / i_link_loss  in  NUM_CH  loss payload.
- o_irq  out  NUM_CH  level interrupt per channel.
- o_soft_rst  out  1  soft reset pulse.

Behaviour:
- Address decode:
  - Channel page: addr[15:12]=0, addr[11:8]=ch, addr[7:0]=offset.
  - Global page: addr[15:12]=4'hF.
  - Write to ch≥NUM_CH or an unmapped offset is ignored; read returns 0.
- Channel offsets:
  - 0x08 TX_CFG (WO, write pulses o_tx_config_done[ch]).
  - 0x10 RX_CFG (WO, write pulses o_rx_config_done[ch]).
  - 0x20 TX_ADDR, 0x28 TX_LENGTH, 0x30 TX_PACKET, 0x40 RX_ADDR, 0x48 RX_CTRL (RW, 64b).
  - 0x38 TX_STATUS (RO) = {4'h9, 50'h0, i_tx_status}.
  - 0x50 RX_STATUS (RO) = {4'hA, 54'h0, i_rx_status}.
  - 0x60 EVT_POP (RO, read pops).
  - 0x68 IRQ_MASK (RW, bits[3:0]).
  - 0x70 IRQ_STAT (W1C, bits[3:0]): [0] tx_done, [1] rx_done, [2] loss, [3] evt_overflow.
- Global offsets:
  - 0xF000 SOFT_RST (write with wdata[0]=1).
  - 0xF008 VERSION (RO) = 64'h0000_2711_0002_0000 | NUM_CH.
  - 0xF010 IRQ_SUMMARY (RO) = o_irq zero-extended.
- Write timing: a write takes effect on the cycle after i_reg_wen. Config-done pulses assert one cycle after i_reg_wen, for one cycle.
- Read timing:
  - Fixed 2-cycle latency: ren at cycle N gives o_reg_rvalid=1 and o_reg_rdata at N+2.
  - rdata holds until the next read.
  - Read and write to the same address in the same cycle: the read returns the old value.
- Reset values:
  - All RW registers, IRQ_STAT, IRQ_MASK and FIFO pointers: 0.
  - All outputs: 0, except config buses, which follow their registers.
- Event capture, per channel, one capture register per source:
  - rx = {4'd2, 18'h0, type, end, chk, num, len}.
  - tx = {4'd1, 44'h0, 16'h5AA5}.
  - loss = {4'd3, 52'h0, i_rx_status, i_sync_loss, i_link_loss}.
- Event push:
  - At most one push per cycle, fixed priority rx > tx > loss.
  - Simultaneous strobes drain over successive cycles; 3 simultaneous events are all in the FIFO within 3 cycles.
  - A source strobing again while its capture is still pending overwrites the capture and sets IRQ_STAT[3].
  - A push into a full FIFO is dropped and sets IRQ_STAT[3].
  - Push and pop in the same cycle on a full FIFO both succeed.
- Event pop:
  - The pop occurs in the cycle the EVT_POP read is decoded; returned data is the head entry.
  - A pop on an empty FIFO returns 64'h0 and leaves the pointers unchanged.
- IRQ status:
  - IRQ_STAT bits set on the corresponding strobe.
  - W1C write in the same cycle as a set: the set wins.
  - o_irq[ch] = |(IRQ_STAT & ~IRQ_MASK), registered.
- Soft reset:
  - o_soft_rst rises one cycle after the write and stays high for exactly SOFT_RST_CYCLES cycles.
  - A rewrite while active restarts the count.
  - Soft reset does not clear registers.
- rst: clears everything immediately, including in-flight reads (rvalid is suppressed), pending captures and the active soft-reset pulse.

Test Plan:
- Write TX_PACKET ch1 = 64'h9000_0020_0010_0366 → o_tx_packet_body[1]=0x0366, o_tx_body_num[1]=0x0010, o_tx_packet_tail[1]=0x0020, o_tx_mode[1]=1, o_loopback_ena[1]=1, o_tx_pre[1]=0; ch0 outputs unchanged; read back gives the same value with rvalid at N+2.
- Simultaneous rx/tx/loss strobes on ch0 → three EVT_POP reads return the types 2, 1, 3 in that order; a fourth read returns 0; IRQ_STAT=4'h7.
- Nine tx strobes with EVT_DEPTH=8 and no pops → 8 entries retained, IRQ_STAT[3]=1; W1C 4'h8 clears bit 3 only.
- IRQ_MASK=4'hF with an rx strobe → o_irq stays 0; then set IRQ_MASK=0 → o_irq=1 two cycles later; W1C 4'h2 → o_irq returns to 0.
- SOFT_RST write, then a rewrite 100 cycles later → o_soft_rst high for 100+255 cycles total.
- Read of ch=NUM_CH and of offset 0x58 → rdata=0, rvalid=1; writes to them leave all registers unchanged.
